// File: rtl/regfile_pkg.sv
// regfile_pkg: shared types and helpers for the multi-port register file.
//   BYTE_W       - width of one write-strobe lane
//   clr_state_t  - bulk-clear sequencer states
//   addr_w()     - address width for a given register count, never below 1
package regfile_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } clr_state_t;

  function automatic int addr_w(input int num);
    return (num <= 2) ? 1 : $clog2(num);
  endfunction

endpackage

// File: rtl/reg_en_be.sv
// reg_en_be: one BITS-wide storage register with per-byte write enables
// and a synchronous clear that dominates any byte write in the same cycle.
// Ports:
//   clk  in  clock
//   clr  in  synchronous clear, active-high
//   be   in  [BE]   byte write enables
//   d    in  [BITS] write data
//   q    out [BITS] stored value
module reg_en_be
  import regfile_pkg::*;
#(
  parameter  int BITS = 32,
  localparam int BE   = BITS / BYTE_W
) (
  input  logic            clk,
  input  logic            clr,
  input  logic [BE-1:0]   be,
  input  logic [BITS-1:0] d,
  output logic [BITS-1:0] q
);

  logic [BITS-1:0] q_q, q_d;

  always_comb begin
    q_d = q_q;
    for (int b = 0; b < BE; b++)
      if (be[b]) q_d[b*BYTE_W +: BYTE_W] = d[b*BYTE_W +: BYTE_W];
    if (clr) q_d = '0;
  end

  always_ff @(posedge clk) q_q <= q_d;

  assign q = q_q;

endmodule

// File: rtl/register_file_mp.sv
// register_file_mp: multi-port, byte-enabled architectural register store
// with registered reads and a sequenced bulk-clear engine.
// Optional feature macro: REGFILE_BYPASS_EN (same-edge write-to-read
// forwarding; when undefined a read returns the pre-write value).
// Ports:
//   clk, reset_n (synchronous, active-high despite the name)
//   wr_valid/wr_addr/wr_be/wr_data [WPORTS]  write ports, wr_ready shared
//   rd_en/rd_addr [RPORTS] -> rd_data/rd_valid, one-cycle latency
//   clr_req -> busy for exactly NUM cycles while registers are zeroed
//   err_addr  sticky flag for any out-of-range read or accepted write
module register_file_mp
  import regfile_pkg::*;
#(
  parameter  int BITS      = 32,
  parameter  int NUM       = 7,
  parameter  int WPORTS    = 2,
  parameter  int RPORTS    = 2,
  parameter  int ZERO_REG0 = 0,
  localparam int AW        = addr_w(NUM),
  localparam int BE        = BITS / BYTE_W
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic [WPORTS-1:0]             wr_valid,
  output logic                          wr_ready,
  input  logic [WPORTS-1:0][AW-1:0]     wr_addr,
  input  logic [WPORTS-1:0][BE-1:0]     wr_be,
  input  logic [WPORTS-1:0][BITS-1:0]   wr_data,
  input  logic [RPORTS-1:0]             rd_en,
  input  logic [RPORTS-1:0][AW-1:0]     rd_addr,
  output logic [RPORTS-1:0][BITS-1:0]   rd_data,
  output logic [RPORTS-1:0]             rd_valid,
  input  logic                          clr_req,
  output logic                          busy,
  output logic                          err_addr
);

  clr_state_t                    state_q, state_d;
  logic [AW-1:0]                 cnt_q, cnt_d;
  logic [RPORTS-1:0][BITS-1:0]   rd_data_q, rd_data_d;
  logic [RPORTS-1:0]             rd_valid_q, rd_valid_d;
  logic                          err_q, err_d;

  logic [NUM-1:0][BITS-1:0]      store;
  logic [NUM-1:0][BE-1:0]        wen;
  logic [NUM-1:0][BITS-1:0]      wval;
  logic [NUM-1:0]                reg_clr;
  logic                          wr_err, rd_err;

  assign wr_ready = (state_q == IDLE);
  assign busy     = (state_q == CLEAR);

  // Write merge: ports are visited in ascending order so for every byte
  // lane the highest-indexed port with its strobe set ends up winning.
  // Out-of-range addresses match no register and simply flag an error.
  always_comb begin
    wen    = '0;
    wval   = '0;
    wr_err = 1'b0;
    for (int p = 0; p < WPORTS; p++) begin
      if (wr_valid[p] && wr_ready && !reset_n) begin
        if (32'(wr_addr[p]) >= NUM) wr_err = 1'b1;
        for (int r = 0; r < NUM; r++) begin
          if (!(ZERO_REG0 != 0 && r == 0) && wr_addr[p] == AW'(r)) begin
            for (int b = 0; b < BE; b++) begin
              if (wr_be[p][b]) begin
                wen[r][b]                   = 1'b1;
                wval[r][b*BYTE_W +: BYTE_W] = wr_data[p][b*BYTE_W +: BYTE_W];
              end
            end
          end
        end
      end
    end
  end

  // Clear sequencer: one register per cycle, index 0 first.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (clr_req) begin
          state_d = CLEAR;
          cnt_d   = '0;
        end
      end
      CLEAR: begin
        cnt_d = cnt_q + AW'(1);
        if (cnt_q == AW'(NUM - 1)) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  for (genvar r = 0; r < NUM; r++) begin : g_reg
    assign reg_clr[r] = reset_n || (state_q == CLEAR && cnt_q == AW'(r));
    reg_en_be #(.BITS(BITS)) u_reg (
      .clk (clk),
      .clr (reg_clr[r]),
      .be  (wen[r]),
      .d   (wval[r]),
      .q   (store[r])
    );
  end

  // Read muxes. Out-of-range and (optionally) register-0 reads match no
  // entry and fall through to zero.
  always_comb begin
    rd_data_d  = rd_data_q;
    rd_valid_d = '0;
    rd_err     = 1'b0;
    for (int i = 0; i < RPORTS; i++) begin
      if (rd_en[i]) begin
        rd_valid_d[i] = 1'b1;
        rd_data_d[i]  = '0;
        if (32'(rd_addr[i]) >= NUM) rd_err = 1'b1;
        for (int r = 0; r < NUM; r++) begin
          if (!(ZERO_REG0 != 0 && r == 0) && rd_addr[i] == AW'(r)) begin
`ifdef REGFILE_BYPASS_EN
            for (int b = 0; b < BE; b++)
              rd_data_d[i][b*BYTE_W +: BYTE_W] = wen[r][b] ? wval[r][b*BYTE_W +: BYTE_W]
                                                           : store[r][b*BYTE_W +: BYTE_W];
`else
            rd_data_d[i] = store[r];
`endif
          end
        end
      end
    end
  end

  assign err_d = err_q | wr_err | rd_err;

  always_ff @(posedge clk) begin
    if (reset_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      err_q      <= err_d;
    end
  end

  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;
  assign err_addr = err_q;

endmodule
